imm_control_sequencer: RTL and testbench

IMM_CONTROL_SEQUENCER -- requirements
Module: imm_control_sequencer

---
 rtl/imm_control_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_imm_control_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_control_sequencer.sv
// ----------------------------------------------------------------------------
// imm_control_sequencer
//   Hardwired control sequencer for the immediate-form instructions
//   ldi / addi / andi / ori. One instruction is fetched, decoded and executed
//   in the steps T0..T5. Any other opcode drops the sequencer into FAULT,
//   which is left only through clr.
//
//   Optional feature: define SEQ_WATCHDOG_EN to bound the T1 memory wait.
//   Once WD_LIMIT T1 cycles have passed with mem_ready low, the sequencer
//   enters FAULT and raises timeout. Without the macro, T1 waits
//   indefinitely and timeout is tied low.
//
// Ports
//   clk, clr              clock, synchronous active-high reset
//   run                   permit fetch of the next instruction
//   mem_ready             RAM read data valid (ends the T1 wait)
//   opcode[4:0]           IR[31:27]
//   PCout..Cout           fetch / ALU datapath strobes
//   Gra, Grb, Rin_in,
//   BAout                 register-select strobes
//   ALUControl[ALU_W-1:0] one-hot ALU operation, non-zero only in T4
//   step[2:0]             current state code (IDLE=0 .. T5=6, FAULT=7)
//   done                  instruction-complete pulse (T5)
//   illegal               sticky illegal-opcode fault
//   timeout               sticky memory-wait watchdog fault
//   instr_count           completed instructions, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module imm_control_sequencer #(
  parameter int unsigned ALU_W    = 12,
  parameter int unsigned ALU_ADD  = 0,
  parameter int unsigned ALU_AND  = 1,
  parameter int unsigned ALU_OR   = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WD_LIMIT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [4:0]       opcode,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             PCin,
  output logic             Zlowout,
  output logic             MDRRead,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Cout,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin_in,
  output logic             BAout,
  output logic [ALU_W-1:0] ALUControl,
  output logic [2:0]       step,
  output logic             done,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_T4    = 3'd5,
    S_T5    = 3'd6,
    S_FAULT = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ALU_SEL_ADD = 2'd0,
    ALU_SEL_AND = 2'd1,
    ALU_SEL_OR  = 2'd2
  } alu_sel_e;

  state_e           state_q,    state_d;
  alu_sel_e         alu_sel_q,  alu_sel_d;
  logic             first_t1_q, first_t1_d;
  logic             illegal_q,  illegal_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // All four legal opcodes share the prefix 010; the low two bits pick the op.
  logic opcode_legal;
  logic opcode_is_ldi;
  assign opcode_legal  = (opcode[4:2] == 3'b010);
  assign opcode_is_ldi = (opcode == 5'b01000);

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            wd_expire;

  // Held at zero outside T1, so it is already clear on T1 entry.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == S_T1) begin
      wd_cnt_d = mem_ready ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
  end

  // The cycle that would bring the count to WD_LIMIT ends the wait.
  assign wd_expire = (state_q == S_T1) && !mem_ready && (wd_cnt_q == WD_LAST);
  assign timeout   = timeout_q;
`else
  logic wd_expire;
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    alu_sel_d = alu_sel_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
`ifdef SEQ_WATCHDOG_EN
    timeout_d = timeout_q;
`endif

    // T1 is entered only from T0, so this marks the first T1 cycle.
    first_t1_d = (state_q == S_T0);

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: state_d = S_T1;
      S_T1: begin
        if (mem_ready) begin
          state_d = S_T2;
        end else if (wd_expire) begin
          state_d = S_FAULT;
`ifdef SEQ_WATCHDOG_EN
          timeout_d = 1'b1;
`endif
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (opcode_legal) begin
          state_d = S_T4;
          unique case (opcode[1:0])
            2'b10:   alu_sel_d = ALU_SEL_AND;
            2'b11:   alu_sel_d = ALU_SEL_OR;
            default: alu_sel_d = ALU_SEL_ADD;
          endcase
        end else begin
          state_d   = S_FAULT;
          illegal_d = 1'b1;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = run ? S_T0 : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      alu_sel_q  <= ALU_SEL_ADD;
      first_t1_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      alu_sel_q  <= alu_sel_d;
      first_t1_q <= first_t1_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    Zlowout    = 1'b0;
    MDRRead    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Cout       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Rin_in     = 1'b0;
    BAout      = 1'b0;
    ALUControl = '0;
    done       = 1'b0;

    unique case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        // PC reload happens once; the read strobes stay up for the whole wait.
        Zlowout = first_t1_q;
        PCin    = first_t1_q;
        MDRRead = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Grb   = 1'b1;
        Yin   = 1'b1;
        // opcode comes from IR, which was loaded at the T2 edge and is
        // stable for the whole of T3.
        BAout = opcode_is_ldi;
      end
      S_T4: begin
        Cout = 1'b1;
        Zin  = 1'b1;
        unique case (alu_sel_q)
          ALU_SEL_AND: ALUControl[ALU_AND] = 1'b1;
          ALU_SEL_OR:  ALUControl[ALU_OR]  = 1'b1;
          default:     ALUControl[ALU_ADD] = 1'b1;
        endcase
      end
      S_T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin_in  = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign step        = state_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_imm_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_imm_control_sequencer
//   Self-checking bench for imm_control_sequencer (default parameters).
//   Table of single-instruction vectors, hand-written multi-cycle sequences
//   (back-to-back, fault hold, memory wait / watchdog, reset mid-instruction)
//   and a randomized run compared against an instruction-level model.
// ----------------------------------------------------------------------------
module tb_imm_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready;
  logic [4:0]  opcode;
  logic        PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin;
  logic        MDRout, IRin, Yin, Cout, Gra, Grb, Rin_in, BAout;
  logic [11:0] ALUControl;
  logic [2:0]  step;
  logic        done, illegal, timeout;
  logic [15:0] instr_count;

  imm_control_sequencer #(
    .ALU_W(12), .ALU_ADD(0), .ALU_AND(1), .ALU_OR(2), .CNT_W(16), .WD_LIMIT(15)
  ) dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .opcode(opcode),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
    .Zlowout(Zlowout), .MDRRead(MDRRead), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Cout(Cout), .Gra(Gra), .Grb(Grb),
    .Rin_in(Rin_in), .BAout(BAout), .ALUControl(ALUControl), .step(step),
    .done(done), .illegal(illegal), .timeout(timeout),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {PCout,MARin,IncPC,Zin,PCin,Zlowout,MDRRead,MDRin,
  //  MDRout,IRin,Yin,Cout,Gra,Grb,Rin_in,BAout}
  logic [15:0] ctrl;
  assign ctrl = {PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin,
                 MDRout, IRin, Yin, Cout, Gra, Grb, Rin_in, BAout};

  localparam logic [4:0] OP_LDI  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_ANDI = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clr = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 5'd0;
    tick;
    clr = 1'b0;
  endtask

  // Controls each step must show, transcribed from the step descriptions.
  function automatic logic [15:0] exp_ctrl(input int s, input bit first, input bit ldi);
    case (s)
      1:       return 16'hF000;                    // PCout MARin IncPC Zin
      2:       return first ? 16'h0F00 : 16'h0300; // (PCin Zlowout) MDRRead MDRin
      3:       return 16'h00C0;                    // MDRout IRin
      4:       return ldi ? 16'h0025 : 16'h0024;   // Yin Grb (BAout)
      5:       return 16'h1010;                    // Zin Cout
      6:       return 16'h040A;                    // Zlowout Gra Rin_in
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [11:0] alu_exp(input logic [4:0] op);
    case (op)
      OP_LDI, OP_ADDI: return 12'h001;
      OP_ANDI:         return 12'h002;
      OP_ORI:          return 12'h004;
      default:         return 12'h000;
    endcase
  endfunction

  // Step expected k cycles after T0 of an instruction with w wait cycles.
  function automatic int step_of(input int k, input int w);
    if (k == 0) return 1;
    if (k <= w + 1) return 2;
    return k - w + 1;
  endfunction

  typedef struct {
    logic [4:0]  op;
    int          waits;
    logic [11:0] alu;
    logic        ba;
    logic        fault;
  } vec_t;

  vec_t vecs[8];

  // Global time bound so a stuck run still reports.
  initial begin
    #1_000_000;
    $display("FAIL time_limit: got timeout expected $finish");
    $fatal(1, "time limit");
  end

  initial begin
    int ms, mk, mw, mcnt;
    logic [4:0] mop;

    vecs[0] = '{OP_LDI,   0, 12'h001, 1'b1, 1'b0};
    vecs[1] = '{OP_ADDI,  1, 12'h001, 1'b0, 1'b0};
    vecs[2] = '{OP_ANDI,  3, 12'h002, 1'b0, 1'b0};
    vecs[3] = '{OP_ORI,   2, 12'h004, 1'b0, 1'b0};
    vecs[4] = '{5'b00000, 0, 12'h000, 1'b0, 1'b1};
    vecs[5] = '{5'b11111, 1, 12'h000, 1'b0, 1'b1};
    vecs[6] = '{5'b01100, 0, 12'h000, 1'b0, 1'b1};
    vecs[7] = '{5'b00111, 2, 12'h000, 1'b0, 1'b1};

    // ---- Reset state --------------------------------------------------------
    clr = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = OP_LDI;
    tick; tick;
    chk("rst_step",  step, 3'd0);
    chk("rst_ctrl",  ctrl, 16'h0);
    chk("rst_alu",   ALUControl, 12'h0);
    chk("rst_done",  done, 1'b0);
    chk("rst_ill",   illegal, 1'b0);
    chk("rst_tmo",   timeout, 1'b0);
    chk("rst_cnt",   instr_count, 16'd0);
    clr = 1'b0; run = 1'b0;
    tick;
    chk("idle_hold", step, 3'd0);

    // ---- Table vectors: one instruction each, run dropped after T0 ----------
    foreach (vecs[i]) begin
      do_reset;
      run = 1'b1; opcode = vecs[i].op; mem_ready = 1'b0;
      tick;
      chk("tab_t0", step, 3'd1);
      run = 1'b0;
      for (int c = 0; c <= vecs[i].waits; c++) begin
        tick;
        chk("tab_t1", step, 3'd2);
        chk("tab_t1_ctrl", ctrl, exp_ctrl(2, c == 0, 1'b0));
        mem_ready = (c == vecs[i].waits);
      end
      tick;
      chk("tab_t2", step, 3'd3);
      mem_ready = 1'b0;
      tick;
      chk("tab_t3", step, 3'd4);
      chk("tab_t3_ba", BAout, vecs[i].ba);
      tick;
      if (vecs[i].fault) begin
        chk("tab_fault_step", step, 3'd7);
        chk("tab_fault_ill",  illegal, 1'b1);
        chk("tab_fault_ctrl", ctrl, 16'h0);
      end else begin
        chk("tab_t4", step, 3'd5);
        opcode = 5'b00000;  // changing opcode after T3 must not matter
        #1;
        chk("tab_t4_alu", ALUControl, vecs[i].alu);
        tick;
        chk("tab_t5", step, 3'd6);
        chk("tab_t5_done", done, 1'b1);
        chk("tab_t5_alu", ALUControl, 12'h0);
        tick;
        chk("tab_end_step", step, 3'd0);
        chk("tab_end_cnt",  instr_count, 16'd1);
        chk("tab_end_ill",  illegal, 1'b0);
      end
    end

    // ---- Back-to-back addi then ori ----------------------------------------
    do_reset;
    run = 1'b1; mem_ready = 1'b1; opcode = OP_ADDI;
    for (int n = 0; n < 2; n++) begin
      for (int s = 1; s <= 6; s++) begin
        tick;
        chk("b2b_step", step, s);
        if (s == 5) chk("b2b_alu", ALUControl, (n == 0) ? 12'h001 : 12'h004);
        if (s == 6) opcode = OP_ORI;
      end
    end
    run = 1'b0;
    tick;
    chk("b2b_idle", step, 3'd0);
    chk("b2b_cnt",  instr_count, 16'd2);

    // ---- Illegal opcode: FAULT holds, clr leaves it -------------------------
    do_reset;
    run = 1'b1; mem_ready = 1'b1; opcode = 5'b11111;
    for (int s = 1; s <= 4; s++) tick;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("fault_step", step, 3'd7);
      chk("fault_ill",  illegal, 1'b1);
      chk("fault_ctrl", {ctrl, ALUControl, done}, 29'h0);
    end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("fault_clr_step", step, 3'd0);
    chk("fault_clr_ill",  illegal, 1'b0);

    // ---- Memory wait without mem_ready --------------------------------------
    do_reset;
    run = 1'b1; mem_ready = 1'b0; opcode = OP_LDI;
    tick;
    run = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    for (int c = 0; c < 15; c++) begin
      tick;
      chk("wd_wait", step, 3'd2);
    end
    tick;
    chk("wd_fault_step", step, 3'd7);
    chk("wd_fault_tmo",  timeout, 1'b1);
    chk("wd_fault_ill",  illegal, 1'b0);
    chk("wd_fault_ctrl", ctrl, 16'h0);
`else
    for (int c = 0; c < 100; c++) begin
      tick;
      chk("wait_step", step, 3'd2);
    end
    chk("wait_tmo", timeout, 1'b0);
`endif
    // clr wins over run and mem_ready mid-wait / in FAULT
    clr = 1'b1; run = 1'b1; mem_ready = 1'b1;
    tick;
    clr = 1'b0; run = 1'b0;
    chk("wait_clr_step", step, 3'd0);
    chk("wait_clr_ctrl", ctrl, 16'h0);
    chk("wait_clr_tmo",  timeout, 1'b0);

    // ---- clr during T4 after one completed instruction ----------------------
    do_reset;
    run = 1'b1; mem_ready = 1'b1; opcode = OP_ANDI;
    for (int s = 1; s <= 6; s++) tick;
    for (int s = 1; s <= 5; s++) tick;
    chk("t4clr_pre_step", step, 3'd5);
    chk("t4clr_pre_cnt",  instr_count, 16'd1);
    clr = 1'b1;
    tick;
    clr = 1'b0; run = 1'b0;
    chk("t4clr_step", step, 3'd0);
    chk("t4clr_zin",  Zin, 1'b0);
    chk("t4clr_alu",  ALUControl, 12'h0);
    chk("t4clr_cnt",  instr_count, 16'd0);

    // ---- Randomized run against an instruction-level model ------------------
    do_reset;
    ms = 0; mk = 0; mw = 0; mcnt = 0; mop = OP_LDI;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_step", step, ms);
      chk("rnd_ctrl", ctrl, exp_ctrl(ms, mk == 1, mop == OP_LDI));
      chk("rnd_alu",  ALUControl, (ms == 5) ? alu_exp(mop) : 12'h0);
      chk("rnd_done", done, ms == 6);
      chk("rnd_cnt",  instr_count, mcnt);
      chk("rnd_ill",  illegal, 1'b0);

      run       = ($urandom_range(0, 3) != 0);
      mem_ready = (ms == 2) ? (mk > mw) : 1'($urandom_range(0, 1));
      opcode    = (ms >= 1 && ms <= 4) ? mop : 5'($urandom_range(0, 31));
      tick;

      if (ms == 6) mcnt = (mcnt + 1) % 65536;
      if (ms == 0 || ms == 6) begin
        if (run) begin
          ms  = 1;
          mk  = 0;
          mw  = $urandom_range(0, 4);
          mop = {3'b010, 2'($urandom_range(0, 3))};
        end else begin
          ms = 0;
        end
      end else begin
        mk++;
        ms = step_of(mk, mw);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
